// File: rtl/cronometro_ctrl_if.sv
// Pushbutton inputs and control outputs of the stopwatch controller.
// The master side drives the buttons; the slave side is the controller.
interface cronometro_ctrl_if;
  logic       BTN_START;
  logic       BTN_LAP;
  logic       UP;
  logic       CNT_CLR;
  logic       HOLD;
  logic [1:0] STATE;

  modport master (
    output BTN_START, BTN_LAP,
    input  UP, CNT_CLR, HOLD, STATE
  );

  modport slave (
    input  BTN_START, BTN_LAP,
    output UP, CNT_CLR, HOLD, STATE
  );
endinterface

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: synchronizes and debounces the start/stop and lap/reset
// buttons, then runs the IDLE/RUN/LAP/STOP FSM that drives the counter controls.
module cronometro_ctrl #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic             CLK,
  input  logic             CLR,
  cronometro_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam logic [19:0] DEB_LIM = 20'(DEB_CYCLES);

  // Bit 0 is the start button, bit 1 the lap button throughout.
  logic [1:0]  btn;
  logic [1:0]  sync1, sync2;
  logic [1:0]  deb, deb_q, press;
  logic [1:0]  deb_d;
  logic [19:0] cnt_start, cnt_lap;
  logic [19:0] cnt_start_d, cnt_lap_d;

  state_t state_q, state_d;
  logic   up_q, hold_q, clr_q;

  assign btn = {bus.BTN_LAP, bus.BTN_START};

  // Returns {next debounced level, next stability count}.
  function automatic logic [20:0] deb_step(input logic s, input logic d,
                                           input logic [19:0] c);
    logic [20:0] r;
    if (s == d)
      r = {d, 20'd0};
    else if (c + 20'd1 == DEB_LIM)
      r = {s, 20'd0};
    else
      r = {d, c + 20'd1};
    return r;
  endfunction

  always_comb begin
    {deb_d[0], cnt_start_d} = deb_step(sync2[0], deb[0], cnt_start);
    {deb_d[1], cnt_lap_d}   = deb_step(sync2[1], deb[1], cnt_lap);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      sync1     <= '0;
      sync2     <= '0;
      deb       <= '0;
      deb_q     <= '0;
      cnt_start <= '0;
      cnt_lap   <= '0;
    end else begin
      sync1     <= btn;
      sync2     <= sync1;
      deb       <= deb_d;
      deb_q     <= deb;
      cnt_start <= cnt_start_d;
      cnt_lap   <= cnt_lap_d;
    end
  end

  // Only rising debounced levels are events; releases are silent.
  assign press = deb & ~deb_q;

  // Start is evaluated first so a simultaneous lap press is dropped.
  always_comb begin
    state_d = state_q;
    if (press[0]) begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN:  state_d = STOP;
        LAP:  state_d = STOP;
        STOP: state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (press[1]) begin
      case (state_q)
        RUN:  state_d = LAP;
        LAP:  state_d = RUN;
        STOP: state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with STATE.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      hold_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= (state_d == RUN) || (state_d == LAP);
      hold_q  <= (state_d == LAP);
      clr_q   <= (state_q == STOP) && (state_d == IDLE);
    end
  end

  assign bus.STATE   = state_q;
  assign bus.UP      = up_q;
  assign bus.HOLD    = hold_q;
  assign bus.CNT_CLR = clr_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Bench for cronometro_ctrl with DEB_CYCLES=4: directed scenarios plus random
// button activity, all compared against a table-driven reference model.
module tb_cronometro_ctrl;

  localparam int unsigned DEB = 4;

  logic clk;
  logic clr;

  cronometro_ctrl_if bus ();

  cronometro_ctrl #(.DEB_CYCLES(DEB)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: state codes 0..3, next-state tables indexed by state.
  int unsigned nxt_on_start [4] = '{1, 3, 3, 1};
  int unsigned nxt_on_lap   [4] = '{0, 2, 1, 0};
  int unsigned m_state;
  int unsigned m_clr;
  int unsigned m_d1 [2];
  int unsigned m_d2 [2];
  int unsigned m_lvl [2];
  int unsigned m_lvl_prev [2];
  int unsigned m_run [2];

  task automatic model_reset();
    m_state = 0;
    m_clr   = 0;
    for (int b = 0; b < 2; b++) begin
      m_d1[b] = 0; m_d2[b] = 0; m_lvl[b] = 0; m_lvl_prev[b] = 0; m_run[b] = 0;
    end
  endtask

  task automatic model_step(input logic s, input logic l);
    bit ev_s, ev_l;
    int unsigned ns;
    ev_s = (m_lvl[0] == 1) && (m_lvl_prev[0] == 0);
    ev_l = (m_lvl[1] == 1) && (m_lvl_prev[1] == 0);
    ns = m_state;
    if (ev_s)      ns = nxt_on_start[m_state];
    else if (ev_l) ns = nxt_on_lap[m_state];
    m_clr   = (m_state == 3 && ns == 0) ? 1 : 0;
    m_state = ns;
    for (int b = 0; b < 2; b++) begin
      m_lvl_prev[b] = m_lvl[b];
      if (m_d2[b] == m_lvl[b]) begin
        m_run[b] = 0;
      end else begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_lvl[b] = m_d2[b];
          m_run[b] = 0;
        end
      end
    end
    m_d2[0] = m_d1[0]; m_d2[1] = m_d1[1];
    m_d1[0] = s;       m_d1[1] = l;
  endtask

  task automatic compare_model();
    check("state",   bus.STATE,   m_state);
    check("up",      bus.UP,      (m_state == 1 || m_state == 2) ? 1 : 0);
    check("hold",    bus.HOLD,    (m_state == 2) ? 1 : 0);
    check("cnt_clr", bus.CNT_CLR, m_clr);
  endtask

  task automatic cycle(input logic s, input logic l);
    bus.BTN_START = s;
    bus.BTN_LAP   = l;
    @(posedge clk);
    model_step(s, l);
    #1;
    compare_model();
  endtask

  task automatic hold_for(input logic s, input logic l, input int n);
    repeat (n) cycle(s, l);
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_state"},   bus.STATE,   0);
    check({tag, "_up"},      bus.UP,      0);
    check({tag, "_hold"},    bus.HOLD,    0);
    check({tag, "_cnt_clr"}, bus.CNT_CLR, 0);
  endtask

  // Called one time unit after a rising edge; pulses CLR between edges.
  task automatic pulse_reset();
    #2 clr = 1'b1;
    #1 check_reset_zero("rst_mid");
    model_reset();
    #2 clr = 1'b0;
  endtask

  int unsigned hold_s, hold_l;
  logic rs, rl;

  initial begin
    clr = 1'b1;
    bus.BTN_START = 1'b0;
    bus.BTN_LAP   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_zero("rst_init");
    #2 clr = 1'b0;
    hold_for(0, 0, 5);

    // Start latency: change lands exactly on the 7th edge of the press.
    hold_for(1, 0, 6);
    check("lat_early", bus.STATE, 0);
    cycle(1, 0);
    check("lat_state", bus.STATE, 1);
    check("lat_up",    bus.UP,    1);
    hold_for(1, 0, 10);
    check("held_once", bus.STATE, 1);
    hold_for(0, 0, 8);
    hold_for(1, 0, 8);
    check("stop_state", bus.STATE, 3);
    check("stop_up",    bus.UP,    0);
    hold_for(0, 0, 8);

    // Clear from STOP: one-cycle CNT_CLR.
    hold_for(0, 1, 6);
    cycle(0, 1);
    check("clr_state", bus.STATE,   0);
    check("clr_pulse", bus.CNT_CLR, 1);
    cycle(0, 1);
    check("clr_once",  bus.CNT_CLR, 0);
    check("clr_up",    bus.UP,      0);
    hold_for(0, 0, 8);

    // Bounce rejection, then one clean press.
    repeat (10) begin
      hold_for(1, 0, 3);
      hold_for(0, 0, 1);
    end
    check("bounce_none", bus.STATE, 0);
    hold_for(1, 0, 5);
    hold_for(0, 0, 10);
    check("bounce_one", bus.STATE, 1);

    // Lap cycle.
    hold_for(0, 1, 8);
    check("lap_state", bus.STATE, 2);
    check("lap_hold",  bus.HOLD,  1);
    check("lap_up",    bus.UP,    1);
    hold_for(0, 0, 8);
    hold_for(0, 1, 8);
    check("unlap_state", bus.STATE, 1);
    check("unlap_hold",  bus.HOLD,  0);
    hold_for(0, 0, 8);

    // Simultaneous press from RUN: start wins.
    hold_for(1, 1, 8);
    check("simul_state", bus.STATE, 3);
    check("simul_hold",  bus.HOLD,  0);
    hold_for(0, 0, 8);

    // Button held through reset release counts as a fresh press.
    hold_for(1, 0, 3);
    pulse_reset();
    hold_for(1, 0, 6);
    check("rsthold_early", bus.STATE, 0);
    cycle(1, 0);
    check("rsthold_state", bus.STATE, 1);
    hold_for(0, 0, 8);

    // Random button activity with occasional asynchronous resets.
    hold_s = 0; hold_l = 0; rs = 1'b0; rl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_s == 0) begin
        rs = 1'($urandom_range(0, 1));
        hold_s = $urandom_range(1, 12);
      end
      if (hold_l == 0) begin
        rl = 1'($urandom_range(0, 1));
        hold_l = $urandom_range(1, 12);
      end
      hold_s--; hold_l--;
      cycle(rs, rl);
      if ($urandom_range(0, 399) == 0) pulse_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
